// File: rtl/microsys_pkg.sv
// Shared constants and loader state encoding for the microsys program memory.
package microsys_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/ram_sp_64x8.sv
// Synchronous RAM with one muxed write port and a registered read port on the CPU address.
module ram_sp_64x8 #(
    parameter int ADDR_W = microsys_pkg::ADDR_W,
    parameter int DATA_W = microsys_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Read samples the array before this cycle's write lands: same-address access returns old data.
    always_comb begin
        rdata_d = mem_q[raddr];
    end

    // Array contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prog_loader.sv
// Program memory plus framed-stream loader; holds the CPU in reset until a checksummed image lands.
// Stream handshake: a byte transfers on a posedge where load_valid and load_ready are both high.
module prog_loader #(
    parameter int ADDR_W = microsys_pkg::ADDR_W,
    parameter int DATA_W = microsys_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rw,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_reset,
    output logic              loaded,
    output logic              error
);

    import microsys_pkg::*;

    // One extra bit so a full-depth frame (LEN byte 0) has a distinct terminal count.
    localparam int CNT_W = ADDR_W + 1;

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_inc;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              load_ready_q, load_ready_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              loaded_q, loaded_d;
    logic              error_q, error_d;
    logic              xfer;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    assign xfer      = load_valid & load_ready_q;
    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        sum_d   = sum_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (load_data[ADDR_W-1:0] == '0) begin
                        len_d = CNT_W'(2 ** ADDR_W);
                    end else begin
                        len_d = CNT_W'(load_data[ADDR_W-1:0]);
                    end
                    count_d = '0;
                    sum_d   = '0;
                    error_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    sum_d   = sum_q + load_data;
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (load_data == sum_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                if (load_start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change on the same edge as the FSM.
        load_ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == CHECK);
        cpu_reset_d  = (state_d != RUN);
        loaded_d     = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            count_q      <= '0;
            sum_q        <= '0;
            load_ready_q <= 1'b1;
            cpu_reset_q  <= 1'b1;
            loaded_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            load_ready_q <= load_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            loaded_q     <= loaded_d;
            error_q      <= error_d;
        end
    end

    // The CPU owns the write port only while running; otherwise the loader does.
    always_comb begin
        if (state_q == RUN) begin
            ram_we    = ~cpu_rw;
            ram_waddr = cpu_addr;
            ram_wdata = cpu_wdata;
        end else begin
            ram_we    = (state_q == LOAD) && xfer;
            ram_waddr = count_q[ADDR_W-1:0];
            ram_wdata = load_data;
        end
    end

    ram_sp_64x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (cpu_addr),
        .rdata (cpu_rdata)
    );

    assign load_ready = load_ready_q;
    assign cpu_reset  = cpu_reset_q;
    assign loaded     = loaded_q;
    assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame loads, checksum failure, CPU port timing, restart and reset.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_start;
  logic [5:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_rw;
  logic [7:0] cpu_rdata;
  logic       cpu_reset;
  logic       loaded;
  logic       error;

  int n_cmp = 0;
  int n_bad = 0;

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_start (load_start),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rw     (cpu_rw),
    .cpu_rdata  (cpu_rdata),
    .cpu_reset  (cpu_reset),
    .loaded     (loaded),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    load_valid = 1'b1;
    load_data  = b;
    w = 0;
    while (!load_ready && w < 50) begin
      tick();
      w++;
    end
    check("ready_wait", load_ready, 1);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic cpu_read_chk(input string tag, input logic [5:0] a, input logic [7:0] exp);
    cpu_addr = a;
    cpu_rw   = 1'b1;
    tick();
    check(tag, cpu_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_start = 1'b0;
    cpu_addr   = 6'h00;
    cpu_wdata  = 8'h00;
    cpu_rw     = 1'b1;
    tick();
    tick();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_loaded", loaded, 0);
    check("rst_error", error, 0);
    check("rst_ready", load_ready, 1);
    check("rst_rdata", cpu_rdata, 8'h00);
    reset = 1'b0;
    tick();

    // Frame 03,3E,7F,C0 with checksum 7D
    send_byte(8'h03);
    send_byte(8'h3E);
    send_byte(8'h7F);
    send_byte(8'hC0);
    check("t1_pre_loaded", loaded, 0);
    check("t1_pre_cpu_reset", cpu_reset, 1);
    send_byte(8'h7D);
    check("t1_loaded", loaded, 1);
    check("t1_cpu_reset", cpu_reset, 0);
    check("t1_ready", load_ready, 0);
    check("t1_error", error, 0);
    cpu_read_chk("t1_mem0", 6'h00, 8'h3E);
    cpu_read_chk("t1_mem1", 6'h01, 8'h7F);
    cpu_read_chk("t1_mem2", 6'h02, 8'hC0);

    // Restart from RUN
    pulse_start();
    check("t5_cpu_reset", cpu_reset, 1);
    check("t5_loaded", loaded, 0);
    check("t5_ready", load_ready, 1);

    // Full-depth frame: LEN 0 means 64 bytes, data i, sum of 0..63 = 0x7E0 -> E0
    send_byte(8'h00);
    for (int i = 0; i < 64; i++) begin
      send_byte(8'(i));
    end
    check("t2_pre_loaded", loaded, 0);
    send_byte(8'hE0);
    check("t2_loaded", loaded, 1);
    check("t2_cpu_reset", cpu_reset, 0);
    cpu_read_chk("t2_mem00", 6'h00, 8'h00);
    cpu_read_chk("t2_mem03", 6'h03, 8'h03);
    cpu_read_chk("t2_mem20", 6'h20, 8'h20);
    cpu_read_chk("t2_mem3e", 6'h3E, 8'h3E);
    cpu_read_chk("t2_mem3f", 6'h3F, 8'h3F);

    // CPU write then read of the same address: old data first, new data next cycle
    cpu_addr  = 6'h3F;
    cpu_wdata = 8'hA5;
    cpu_rw    = 1'b0;
    tick();
    check("t4_old_data", cpu_rdata, 8'h3F);
    cpu_rw = 1'b1;
    tick();
    check("t4_new_data", cpu_rdata, 8'hA5);

    // Bad checksum: 11+22 = 33, send 00
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h00);
    check("t3_error", error, 1);
    check("t3_cpu_reset", cpu_reset, 1);
    check("t3_ready", load_ready, 0);
    check("t3_loaded", loaded, 0);
    cpu_read_chk("t3_mem0", 6'h00, 8'h11);
    cpu_read_chk("t3_mem1", 6'h01, 8'h22);
    cpu_read_chk("t3_mem2_kept", 6'h02, 8'h02);
    cpu_addr  = 6'h05;
    cpu_wdata = 8'hFF;
    cpu_rw    = 1'b0;
    tick();
    cpu_rw = 1'b1;
    cpu_read_chk("t3_cpu_wr_ignored", 6'h05, 8'h05);
    pulse_start();
    check("t3_restart_ready", load_ready, 1);
    check("t3_error_held", error, 1);

    // Reset part-way through a 5-byte frame
    send_byte(8'h05);
    check("t6_err_clr_on_len", error, 0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_loaded", loaded, 0);
    check("t6_rst_error", error, 0);
    check("t6_rst_cpu_reset", cpu_reset, 1);
    check("t6_rst_ready", load_ready, 1);
    check("t6_rst_rdata", cpu_rdata, 8'h00);

    // Fresh frame; load_start during LOAD is ignored
    send_byte(8'h01);
    pulse_start();
    check("t6_start_ignored_ready", load_ready, 1);
    send_byte(8'h5A);
    send_byte(8'h5A);
    check("t6_loaded", loaded, 1);
    check("t6_error", error, 0);
    cpu_read_chk("t6_mem0", 6'h00, 8'h5A);
    cpu_read_chk("t6_mem1_partial", 6'h01, 8'hBB);
    cpu_read_chk("t6_mem2_kept", 6'h02, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
